// File: rtl/mem_stream_pkg.sv
// Shared types and default widths for the memory read streamer.
package mem_stream_pkg;

   localparam int unsigned MS_ADDR_W = 4;
   localparam int unsigned MS_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [MS_DATA_W-1:0] data;
      logic                 last;
   } fifo_entry_t;

endpackage

// File: rtl/mem_stream_fifo2.sv
// Two-entry synchronous FIFO holding captured read words until the stream accepts them.
module mem_stream_fifo2
   import mem_stream_pkg::*;
#(
   parameter type entry_t = fifo_entry_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  entry_t     push_data_i,
   input  logic       pop_i,
   output logic [1:0] count_o,
   output entry_t     head_o
);

   entry_t     mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;

   // Pointer/count update; storage itself needs no reset since count gates its use.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_read_streamer.sv
// Sweeps a contiguous range of a sync-read memory and streams the words out (valid/ready).
// Optional feature macro: MEM_READ_STREAMER_WRAP_EN (sweeps may wrap past the top address).
module mem_read_streamer
   import mem_stream_pkg::*;
#(
   parameter int unsigned ADDR_W = MS_ADDR_W,
   parameter int unsigned DATA_W = MS_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } entry_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [ADDR_W:0]   remain_q, remain_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              issue;
   logic              handshake;
   logic              range_bad;
   logic [1:0]        fifo_count;
   entry_t            head;
   entry_t            push_entry;

   // Range check at start: only needed when wrapping is not allowed.
`ifdef MEM_READ_STREAMER_WRAP_EN
   assign range_bad = 1'b0;
`else
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned SUM_W = ADDR_W + 2;
   assign range_bad = (SUM_W'(base_addr) + SUM_W'(length)) > SUM_W'(DEPTH);
`endif

   assign handshake = m_valid && m_ready;

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         last_addr_q     <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         last_addr_q     <= last_addr_d;
         remain_q        <= remain_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
         err_q           <= err_d;
      end
   end

   // Next-state: start handling, credit-limited issue, and completion on the last handshake.
   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      last_addr_d     = last_addr_q;
      remain_d        = remain_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b0;
      err_d           = 1'b0;
      issue           = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else if (range_bad) begin
                  err_d = 1'b1;
               end else begin
                  addr_d   = base_addr;
                  remain_d = length;
                  state_d  = ISSUE;
               end
            end
         end
         ISSUE: begin
            // FIFO occupancy plus the word in flight may not exceed two after this cycle's pop.
            if ((3'({1'b0, fifo_count}) + 3'(inflight_q)) < (3'd2 + 3'(handshake))) begin
               issue           = 1'b1;
               inflight_d      = 1'b1;
               inflight_last_d = (remain_q == (ADDR_W+1)'(1));
               last_addr_d     = addr_q;
               addr_d          = addr_q + ADDR_W'(1);
               remain_d        = remain_q - (ADDR_W+1)'(1);
               if (remain_q == (ADDR_W+1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (handshake && m_last) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The read address must reach the memory in the issue cycle itself, so it is muxed live.
   assign mem_addr = issue ? addr_q : last_addr_q;

   assign push_entry = '{data: mem_rd_data, last: inflight_last_q};

   mem_stream_fifo2 #(
      .entry_t (entry_t)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (push_entry),
      .pop_i       (handshake),
      .count_o     (fifo_count),
      .head_o      (head)
   );

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign err     = err_q;
   assign m_valid = (fifo_count != 2'd0);
   assign m_data  = head.data;
   assign m_last  = m_valid && head.last;

endmodule
